// File: rtl/alu_rr_sched_8bits.sv
// ============================================================================
// alu_rr_sched_8bits
//   Round-robin scheduler that shares one 8-bit ALU (ADD/SUB/MUL/DIV) among
//   NUM_REQ requesters. A request is granted in IDLE and its operands are
//   latched. The ALU result is registered in EXEC. The result is returned over
//   a valid/ready response channel in RESP, tagged with the requester index.
//
//   Optional feature macro: ALU_DIV0_CHECK_EN
//     defined   : DIV with B==0 returns 8'hFF and raises rsp_err_o
//     undefined : rsp_err_o is tied low and the raw ALU output is returned
// ============================================================================

// ----------------------------------------------------------------------------
// alu_8bits: purely combinational 8-bit ALU, results truncated to 8 bits
// ----------------------------------------------------------------------------
module alu_8bits (
    input  logic [1:0] op_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] result_o
);

    // Select the operation; 8-bit context keeps the low byte of MUL/SUB
    always_comb begin
        result_o = 8'd0;
        case (op_i)
            2'd0:    result_o = a_i + b_i;
            2'd1:    result_o = a_i - b_i;
            2'd2:    result_o = a_i * b_i;
            default: result_o = a_i / b_i;
        endcase
    end

endmodule

// ----------------------------------------------------------------------------
// alu_rr_sched_8bits: arbiter + operand registers + response channel
// ----------------------------------------------------------------------------
module alu_rr_sched_8bits #(
    parameter int NUM_REQ = 4,   // 2..16
    parameter int ID_W    = 2,   // NUM_REQ <= 2**ID_W
    parameter int CNT_W   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [2*NUM_REQ-1:0]   req_op_i,
    input  logic [8*NUM_REQ-1:0]   req_a_i,
    input  logic [8*NUM_REQ-1:0]   req_b_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic [7:0]             rsp_result_o,
    output logic                   rsp_err_o,
    output logic                   busy_o,
    output logic [CNT_W-1:0]       op_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    id_q;
    logic [1:0]         op_q;
    logic [7:0]         a_q;
    logic [7:0]         b_q;
    logic [7:0]         result_q;
    logic               rsp_valid_q;
    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [ID_W-1:0]    ptr_d;
    logic [7:0]         result_d;
    logic               err_d;
    logic [7:0]         alu_out;

    // Per-requester unpacked views of the flat request buses
    logic [1:0]         op_arr  [NUM_REQ];
    logic [7:0]         a_arr   [NUM_REQ];
    logic [7:0]         b_arr   [NUM_REQ];

    // Candidate k is the requester checked k-th, starting at the RR pointer
    logic [ID_W:0]      cand_sum [NUM_REQ];
    logic [ID_W-1:0]    cand_idx [NUM_REQ];

    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign op_arr[gi] = req_op_i[2*gi +: 2];
        assign a_arr[gi]  = req_a_i[8*gi +: 8];
        assign b_arr[gi]  = req_b_i[8*gi +: 8];
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign cand_sum[gi] = {1'b0, ptr_q} + (ID_W+1)'(gi);
        assign cand_idx[gi] = (cand_sum[gi] >= (ID_W+1)'(NUM_REQ))
                            ? ID_W'(cand_sum[gi] - (ID_W+1)'(NUM_REQ))
                            : cand_sum[gi][ID_W-1:0];
    end

    // Pick the first valid requester at or after the pointer (descending loop
    // so the lowest search offset wins)
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[cand_idx[k]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

    // Accept strobe is only offered in IDLE and is forced low while reset is
    // asserted so every output reads zero during reset
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign req_ready_o[gi] = rst_n_i && (state_q == ST_IDLE) && grant_found
                              && (grant_idx == ID_W'(gi));
    end

    // Pointer moves to the requester just after the winner
    always_comb begin
        ptr_d = grant_idx + ID_W'(1);
        if (grant_idx == ID_W'(NUM_REQ - 1)) begin
            ptr_d = '0;
        end
    end

    alu_8bits u_alu (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (alu_out)
    );

`ifdef ALU_DIV0_CHECK_EN
    // Divide-by-zero overrides the ALU output with all-ones and flags an error
    always_comb begin
        err_d    = (op_q == 2'd3) && (b_q == 8'd0);
        result_d = err_d ? 8'hFF : alu_out;
    end
`else
    // No divide-by-zero handling: raw ALU output, error never raised
    always_comb begin
        err_d    = 1'b0;
        result_d = alu_out;
    end
`endif

    logic err_q;

    // Scheduler FSM: IDLE grants, EXEC captures the ALU, RESP holds the result
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            op_q        <= 2'd0;
            a_q         <= 8'd0;
            b_q         <= 8'd0;
            result_q    <= 8'd0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_found) begin
                        op_q    <= op_arr[grant_idx];
                        a_q     <= a_arr[grant_idx];
                        b_q     <= b_arr[grant_idx];
                        id_q    <= grant_idx;
                        ptr_q   <= ptr_d;
                        busy_q  <= 1'b1;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q    <= result_d;
                    err_q       <= err_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        cnt_q       <= cnt_q + CNT_W'(1);
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = id_q;
    assign rsp_result_o = result_q;
    assign rsp_err_o    = err_q;
    assign busy_o       = busy_q;
    assign op_count_o   = cnt_q;

endmodule

// File: tb/tb_alu_rr_sched_8bits.sv
// ============================================================================
// tb_alu_rr_sched_8bits
//   Directed bench with a scoreboard: the driver pushes the hand-computed
//   response when a grant is seen, and a forked monitor pops and compares on
//   every response handshake.
// ============================================================================
module tb_alu_rr_sched_8bits;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 16;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [2*NUM_REQ-1:0]  req_op = '0;
    logic [8*NUM_REQ-1:0]  req_a = '0;
    logic [8*NUM_REQ-1:0]  req_b = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [ID_W-1:0]       rsp_id;
    logic [7:0]            rsp_result;
    logic                  rsp_err;
    logic                  busy;
    logic [CNT_W-1:0]      op_count;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] res;
        logic       err;
        logic       chk_res;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    alu_rr_sched_8bits #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_result_o (rsp_result),
        .rsp_err_o    (rsp_err),
        .busy_o       (busy),
        .op_count_o   (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pops one expected entry on every response handshake
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_rsp", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    $display("rsp id=%0d result=%02h err=%0b", rsp_id, rsp_result, rsp_err);
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    if (e.chk_res) chk("rsp_result", 32'(rsp_result), 32'(e.res));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
        end
    endtask

    // Present a request on requester idx; on grant push the expected response.
    // Called at a negedge; returns just after the accept edge.
    task automatic issue(input int idx, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] res, input logic err,
                         input logic chk_res, input logic push);
        exp_t e;
        bit   got = 1'b0;
        req_valid[idx]       = 1'b1;
        req_op[2*idx +: 2]   = op;
        req_a[8*idx +: 8]    = a;
        req_b[8*idx +: 8]    = b;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (req_ready[idx]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            chk("grant_timeout", 32'(0), 32'(1));
            req_valid[idx] = 1'b0;
        end else begin
            $display("grant req=%0d op=%0d a=%0d b=%0d", idx, op, a, b);
            chk("grant_onehot", 32'(req_ready), 32'(1 << idx));
            if (push) begin
                e.id = 2'(idx); e.res = res; e.err = err; e.chk_res = chk_res;
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
            // Scramble operands after accept; the latched values must be used
            req_valid[idx]     = 1'b0;
            req_op[2*idx +: 2] = ~op;
            req_a[8*idx +: 8]  = 8'hA5;
            req_b[8*idx +: 8]  = 8'h5A;
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("idle_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        int    ngr;
        int    last;
        int    cyc;
        int    order [5];
        logic [7:0] rr_res [4];
        exp_t  e;

        fork
            monitor();
        join_none

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_op_count", 32'(op_count), 32'(0));
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);

        // ---------------- single ADD, latency ----------------
        issue(0, 2'd0, 8'd2, 8'd2, 8'd4, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("exec_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("exec_busy", 32'(busy), 32'(1));
        chk("exec_req_ready", 32'(req_ready), 32'(0));
        @(negedge clk);
        chk("resp_rsp_valid", 32'(rsp_valid), 32'(1));
        @(negedge clk);
        chk("op_count_1", 32'(op_count), 32'(1));
        chk("idle_busy", 32'(busy), 32'(0));

        // ---------------- SUB / MUL / DIV with A=200 B=100 ----------------
        issue(1, 2'd1, 8'd200, 8'd100, 8'd100, 1'b0, 1'b1, 1'b1);
        wait_idle();
        issue(2, 2'd2, 8'd200, 8'd100, 8'h20, 1'b0, 1'b1, 1'b1);
        wait_idle();
        issue(3, 2'd3, 8'd200, 8'd100, 8'd2, 1'b0, 1'b1, 1'b1);
        wait_idle();

        // ---------------- all four requesting: RR order, spacing ----------------
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
        rr_res[0] = 8'd15; rr_res[1] = 8'd5; rr_res[2] = 8'd50; rr_res[3] = 8'd2;
        req_op    = {2'd3, 2'd2, 2'd1, 2'd0};
        req_a     = {8'd10, 8'd10, 8'd10, 8'd10};
        req_b     = {8'd5, 8'd5, 8'd5, 8'd5};
        req_valid = 4'hF;
        ngr = 0; last = 0; cyc = 0;
        while (ngr < 5 && cyc < 40) begin
            #1;
            if (req_ready != '0) begin
                $display("grant req_ready=%b cycle=%0d", req_ready, cyc);
                chk("rr_order", 32'(req_ready), 32'(1 << order[ngr]));
                if (ngr > 0) chk("rr_spacing", 32'(cyc - last), 32'(3));
                last = cyc;
                e.id = 2'(order[ngr]); e.res = rr_res[order[ngr]]; e.err = 1'b0; e.chk_res = 1'b1;
                exp_q.push_back(e);
                ngr++;
            end
            @(negedge clk);
            cyc++;
        end
        if (ngr < 5) chk("rr_timeout", 32'(ngr), 32'(5));
        req_valid = '0;
        wait_idle();

        // ---------------- response back-pressure ----------------
        rsp_ready = 1'b0;
        issue(1, 2'd0, 8'd3, 8'd4, 8'd7, 1'b0, 1'b1, 1'b1);
        req_valid[2]   = 1'b1;
        req_op[5:4]    = 2'd2;
        req_a[23:16]   = 8'd6;
        req_b[23:16]   = 8'd7;
        @(negedge clk);
        @(negedge clk);
        for (int s = 0; s < 5; s++) begin
            chk("stall_rsp_valid", 32'(rsp_valid), 32'(1));
            chk("stall_rsp_id", 32'(rsp_id), 32'(1));
            chk("stall_rsp_result", 32'(rsp_result), 32'(7));
            chk("stall_req_ready", 32'(req_ready), 32'(0));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        issue(2, 2'd2, 8'd6, 8'd7, 8'd42, 1'b0, 1'b1, 1'b1);
        wait_idle();

        // ---------------- divide by zero ----------------
`ifdef ALU_DIV0_CHECK_EN
        issue(3, 2'd3, 8'd7, 8'd0, 8'hFF, 1'b1, 1'b1, 1'b1);
`else
        issue(3, 2'd3, 8'd7, 8'd0, 8'h00, 1'b0, 1'b0, 1'b1);
`endif
        wait_idle();
        chk("op_count_12", 32'(op_count), 32'(12));

        // ---------------- reset during EXEC ----------------
        issue(0, 2'd0, 8'd9, 8'd9, 8'd18, 1'b0, 1'b1, 1'b0);
        rst_n          = 1'b0;
        req_valid      = 4'b0100;
        req_op[5:4]    = 2'd0;
        req_a[23:16]   = 8'd1;
        req_b[23:16]   = 8'd1;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_op_count", 32'(op_count), 32'(0));
        chk("mid_rst_req_ready", 32'(req_ready), 32'(0));
        chk("mid_rst_rsp_id", 32'(rsp_id), 32'(0));
        chk("mid_rst_result", 32'(rsp_result), 32'(0));
        chk("mid_rst_err", 32'(rsp_err), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(2, 2'd0, 8'd1, 8'd1, 8'd2, 1'b0, 1'b1, 1'b1);
        wait_idle();
        // Pointer is now 3: requester 3 must beat 0 and 1
        req_valid[0] = 1'b1;
        req_valid[1] = 1'b1;
        issue(3, 2'd1, 8'd9, 8'd4, 8'd5, 1'b0, 1'b1, 1'b1);
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        wait_idle();
        chk("op_count_after_rst", 32'(op_count), 32'(2));

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
